conv1d_pe: RTL and testbench
============================

# conv1d_pe

Parametrised successor to the single-channel processing element: a 1-D convolution engine for the ECG arrhythmia DNN. It holds weights for `NUM_FILTERS` kernels and one activation vector in two private scratchpad banks, then computes every valid output position for every filter with a signed MAC. Stride, activation length and ReLU are runtime-configurable; saturating fixed-point rescale and a valid/ready result stream are built in. It sits between the layer sequencer (load/start) and the partial-sum writeback buffer (result stream).

## Interface
- `DATA_WIDTH`, 16: signed operand/result width.
- `ACC_WIDTH`, 40: signed accumulator width.
- `FRAC_BITS`, 0: arithmetic right shift applied to the accumulator before saturation.
- `KERNEL_SIZE`, 3: taps per filter (≥1).
- `NUM_FILTERS`, 2: output channels.
- `ACT_DEPTH`, 64: activation bank depth.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: synchronous, active-high.
- `load_valid  in  1`, `load_ready  out  1`: load handshake.
- `load_sel  in  1`: 0 = weight bank, 1 = activation bank.
- `load_last  in  1`: marks the final word of a burst.
- `load_data  in  DATA_WIDTH`: word to store.
- `load_ovf  out  1`: sticky; a write beyond bank capacity was dropped.
- `start  in  1`: one-cycle compute request.
- `cfg_act_len  in  $clog2(ACT_DEPTH+1)`, `cfg_stride  in  4`, `cfg_relu  in  1`: sampled with `start`.
- `busy  out  1`, `done  out  1`, `cfg_err  out  1`: status.
- `out_valid  out  1`, `out_ready  in  1`: result handshake.
- `out_data  out  DATA_WIDTH`, `out_filter  out  $clog2(NUM_FILTERS)`, `out_index  out  $clog2(ACT_DEPTH)`: result and its coordinates.

## Operation
- States: IDLE, LOAD, FETCH, ACCUM, POST, EMIT, DONE.
- Reset: all outputs 0 except `load_ready` = 0 during reset and 1 afterwards. State → IDLE; load address counters and `load_ovf` cleared. Bank contents are not cleared.
- LOAD (entered from IDLE on `load_valid`):
  - Each accepted word is written to the bank selected by `load_sel`, at that bank's counter, which then increments.
  - Weight layout is filter-major: address = f·KERNEL_SIZE + k.
  - `load_last` accepted → that counter clears and state returns to IDLE.
  - Writes at counter ≥ capacity are dropped and set `load_ovf`; the counter saturates.
  - `load_ready` is 1 only in IDLE and LOAD.
- `start` in IDLE:
  - Latch the configuration. OUT_LEN = (cfg_act_len − KERNEL_SIZE)/cfg_stride + 1 (integer division).
  - If `cfg_act_len` < KERNEL_SIZE, `cfg_act_len` > ACT_DEPTH, or `cfg_stride` == 0: go to DONE with `cfg_err` = 1 and emit no outputs. Otherwise `cfg_err` = 0 and `busy` = 1.
  - `start` outside IDLE is ignored. `start` and `load_valid` together: `start` wins.
- Per output (f, i), in order f outer, i inner:
  - FETCH/ACCUM issue tap k = 0..KERNEL_SIZE−1 at activation address i·stride + k and weight address f·KERNEL_SIZE + k.
  - acc = Σ w·a, with a full-precision signed product, sign-extended into ACC_WIDTH. The accumulator is cleared on tap 0 (no carry between outputs).
- POST: r = acc >>> FRAC_BITS, saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; if `cfg_relu` and r < 0, r = 0.
- EMIT: `out_valid` = 1 with `out_data`, `out_filter` = f and `out_index` = i. These are held stable until `out_ready`; the stall is unbounded.
- After the last handshake: DONE for one cycle (`done` = 1, `busy` = 0), then IDLE.

## Timing
- Scratchpad read latency is 1 cycle; the weight and activation banks are read in parallel, one tap per cycle.
- With `start` sampled at edge 0, `out_valid` rises at edge KERNEL_SIZE+2.
- Handshake at edge t → the next `out_valid` rises at edge t+KERNEL_SIZE+2. There is no overlap between outputs.
- `done` is asserted the cycle after the final handshake. With `cfg_err`, `done` is asserted at edge 1.
- Reset mid-compute or mid-load: abort immediately, reaching IDLE at the next edge. `out_valid` drops and no `done` is produced.
- `busy` is 1 from the edge after `start` until the `done` cycle (exclusive).

## Structure
- `pe_pkg` holds:
  - the state enum `pe_state_e`;
  - the bank-select constants `LOAD_SEL_WEIGHT`/`LOAD_SEL_ACT`;
  - a saturate function parameterised by width.
- Sub-module `pe_spad_bank`: single-port synchronous RAM with 1-cycle read, no reset on storage. Instantiate it twice:
  - weights, depth NUM_FILTERS·KERNEL_SIZE;
  - activations, depth ACT_DEPTH.

## Test plan
- Basic convolution: weights f0 = [1,2,3], f1 = [0,0,1]; activations [1,2,3,4,5]; act_len 5, stride 1, no ReLU → (f0: 14,20,26), (f1: 3,4,5) with indices 0..2; `done` pulses once; first `out_valid` at edge 5.
- Stride: same data, stride 2 → f0: 14,26; f1: 3,5; indices 0,1.
- ReLU and saturation:
  - f0 = [−1,−1,−1] on [1,2,3,4,5] → −6,−9,−12 with `cfg_relu` = 0, and 0,0,0 with `cfg_relu` = 1.
  - weights [32767,32767,0] on [2,2,2] → 32767.
- Backpressure: hold `out_ready` low for 10 cycles on the first result → `out_data`/`out_filter`/`out_index` stable; the sequence then completes unchanged.
- Errors and overflow:
  - `cfg_act_len` = 2 → `done` at edge 1, `cfg_err` = 1, no `out_valid`.
  - loading 7 weights with NUM_FILTERS·KERNEL_SIZE = 6 → `load_ovf` = 1 and the first 6 weights are intact.
- Reset mid-compute: assert `reset` during the second output's ACCUM → all outputs 0 next cycle. A new `start` then reproduces the basic-convolution results from retained bank contents.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types, constants and helpers for the conv1d processing element.
package pe_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFetch,
    StAccum,
    StPost,
    StEmit,
    StDone
  } pe_state_e;

  localparam logic LOAD_SEL_WEIGHT = 1'b0;
  localparam logic LOAD_SEL_ACT    = 1'b1;

  // Clamp a signed value into the range of a two's complement number of the given width.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned       width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end
    return x;
  endfunction

endpackage

// File: rtl/conv1d_pe_if.sv
// Load, control, status and result signals between the sequencer/writeback and the PE.
interface conv1d_pe_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_FILTERS = 2,
  parameter int unsigned ACT_DEPTH   = 64
);
  localparam int unsigned LenW  = $clog2(ACT_DEPTH + 1);
  localparam int unsigned FiltW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int unsigned IdxW  = (ACT_DEPTH > 1) ? $clog2(ACT_DEPTH) : 1;

  logic                  load_valid;
  logic                  load_ready;
  logic                  load_sel;
  logic                  load_last;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ovf;
  logic                  start;
  logic [LenW-1:0]       cfg_act_len;
  logic [3:0]            cfg_stride;
  logic                  cfg_relu;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [FiltW-1:0]      out_filter;
  logic [IdxW-1:0]       out_index;

  modport master (
    output load_valid, load_sel, load_last, load_data, start,
    output cfg_act_len, cfg_stride, cfg_relu, out_ready,
    input  load_ready, load_ovf, busy, done, cfg_err,
    input  out_valid, out_data, out_filter, out_index
  );

  modport slave (
    input  load_valid, load_sel, load_last, load_data, start,
    input  cfg_act_len, cfg_stride, cfg_relu, out_ready,
    output load_ready, load_ovf, busy, done, cfg_err,
    output out_valid, out_data, out_filter, out_index
  );

endinterface

// File: rtl/pe_spad_bank.sv
// Single-port scratchpad: synchronous write, registered 1-cycle read, storage not reset.
module pe_spad_bank #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/conv1d_pe.sv
// 1-D convolution PE: loads weights/activations, then streams one saturated MAC result per
// (filter, position) pair over a valid/ready channel.
module conv1d_pe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned FRAC_BITS   = 0,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned NUM_FILTERS = 2,
  parameter int unsigned ACT_DEPTH   = 64
) (
  input logic        clk,
  input logic        reset,
  conv1d_pe_if.slave bus
);

  localparam int unsigned WDepth = NUM_FILTERS * KERNEL_SIZE;
  localparam int unsigned WAw    = (WDepth > 1) ? $clog2(WDepth) : 1;
  localparam int unsigned AAw    = (ACT_DEPTH > 1) ? $clog2(ACT_DEPTH) : 1;
  localparam int unsigned LenW   = $clog2(ACT_DEPTH + 1);
  localparam int unsigned WCntW  = $clog2(WDepth + 1);
  localparam int unsigned FiltW  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int unsigned TapW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  pe_state_e                    state_q;
  logic [WCntW-1:0]             w_cnt_q;
  logic [LenW-1:0]              a_cnt_q;
  logic [LenW-1:0]              act_len_q;
  logic [3:0]                   stride_q;
  logic                         relu_q;
  logic [FiltW-1:0]             f_q;
  logic [AAw-1:0]               i_q;
  logic [WAw-1:0]               w_base_q;
  logic [AAw-1:0]               a_base_q;
  logic [TapW-1:0]              tap_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic                         load_ready_q;
  logic                         load_ovf_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         cfg_err_q;
  logic                         out_valid_q;
  logic [DATA_WIDTH-1:0]        out_data_q;
  logic [FiltW-1:0]             out_filter_q;
  logic [AAw-1:0]               out_index_q;

  logic                         load_accept;
  logic                         w_we;
  logic                         a_we;
  logic [TapW-1:0]              rd_tap;
  logic [WAw-1:0]               w_addr;
  logic [AAw-1:0]               a_addr;
  logic [DATA_WIDTH-1:0]        w_rdata;
  logic [DATA_WIDTH-1:0]        a_rdata;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic [DATA_WIDTH-1:0]        sat_data;
  logic [DATA_WIDTH-1:0]        post_data;
  logic                         cfg_bad;
  logic                         more_pos;

  assign load_accept = bus.load_valid && load_ready_q && !(state_q == StIdle && bus.start);
  assign w_we = load_accept && (bus.load_sel == LOAD_SEL_WEIGHT) && (32'(w_cnt_q) < WDepth);
  assign a_we = load_accept && (bus.load_sel == LOAD_SEL_ACT) && (32'(a_cnt_q) < ACT_DEPTH);

  // In ACCUM the bank already returns tap_q, so prefetch the following tap.
  always_comb begin
    rd_tap = '0;
    if (state_q == StAccum) begin
      rd_tap = (32'(tap_q) == KERNEL_SIZE - 1) ? tap_q : tap_q + TapW'(1);
    end
  end

  assign w_addr = w_we ? WAw'(w_cnt_q) : w_base_q + WAw'(rd_tap);
  assign a_addr = a_we ? AAw'(a_cnt_q) : a_base_q + AAw'(rd_tap);

  pe_spad_bank #(
    .Width (DATA_WIDTH),
    .Depth (WDepth),
    .AddrW (WAw)
  ) u_wbank (
    .clk_i   (clk),
    .we_i    (w_we),
    .addr_i  (w_addr),
    .wdata_i (bus.load_data),
    .rdata_o (w_rdata)
  );

  pe_spad_bank #(
    .Width (DATA_WIDTH),
    .Depth (ACT_DEPTH),
    .AddrW (AAw)
  ) u_abank (
    .clk_i   (clk),
    .we_i    (a_we),
    .addr_i  (a_addr),
    .wdata_i (bus.load_data),
    .rdata_o (a_rdata)
  );

  assign prod = $signed(w_rdata) * $signed(a_rdata);

  always_comb begin
    acc_d = (tap_q == '0) ? '0 : acc_q;
    acc_d = acc_d + ACC_WIDTH'(prod);
  end

  assign sat_data  = DATA_WIDTH'(saturate(64'(acc_q >>> FRAC_BITS), DATA_WIDTH));
  assign post_data = (relu_q && sat_data[DATA_WIDTH-1]) ? '0 : sat_data;

  assign cfg_bad = (32'(bus.cfg_act_len) < KERNEL_SIZE) || (32'(bus.cfg_act_len) > ACT_DEPTH)
                 || (bus.cfg_stride == '0);
  // Another window fits if the next base plus the kernel stays inside the activation length.
  assign more_pos = (32'(a_base_q) + 32'(stride_q) + KERNEL_SIZE) <= 32'(act_len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      w_cnt_q      <= '0;
      a_cnt_q      <= '0;
      act_len_q    <= '0;
      stride_q     <= '0;
      relu_q       <= 1'b0;
      f_q          <= '0;
      i_q          <= '0;
      w_base_q     <= '0;
      a_base_q     <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      load_ready_q <= 1'b0;
      load_ovf_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_filter_q <= '0;
      out_index_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (load_accept) begin
        if (bus.load_sel == LOAD_SEL_WEIGHT) begin
          if (32'(w_cnt_q) >= WDepth) load_ovf_q <= 1'b1;
          if (bus.load_last) begin
            w_cnt_q <= '0;
          end else if (32'(w_cnt_q) < WDepth) begin
            w_cnt_q <= w_cnt_q + WCntW'(1);
          end
        end else begin
          if (32'(a_cnt_q) >= ACT_DEPTH) load_ovf_q <= 1'b1;
          if (bus.load_last) begin
            a_cnt_q <= '0;
          end else if (32'(a_cnt_q) < ACT_DEPTH) begin
            a_cnt_q <= a_cnt_q + LenW'(1);
          end
        end
      end

      case (state_q)
        StIdle: begin
          load_ready_q <= !bus.start;
          if (bus.start) begin
            act_len_q <= bus.cfg_act_len;
            stride_q  <= bus.cfg_stride;
            relu_q    <= bus.cfg_relu;
            cfg_err_q <= cfg_bad;
            busy_q    <= !cfg_bad;
            f_q       <= '0;
            i_q       <= '0;
            w_base_q  <= '0;
            a_base_q  <= '0;
            state_q   <= StFetch;
          end else if (load_accept && !bus.load_last) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (load_accept && bus.load_last) state_q <= StIdle;
        end
        StFetch: begin
          tap_q <= '0;
          if (cfg_err_q) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StAccum;
          end
        end
        StAccum: begin
          acc_q <= acc_d;
          if (32'(tap_q) == KERNEL_SIZE - 1) begin
            state_q <= StPost;
          end else begin
            tap_q <= tap_q + TapW'(1);
          end
        end
        StPost: begin
          out_data_q   <= post_data;
          out_filter_q <= f_q;
          out_index_q  <= i_q;
          out_valid_q  <= 1'b1;
          state_q      <= StEmit;
        end
        StEmit: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (more_pos) begin
              i_q      <= i_q + AAw'(1);
              a_base_q <= a_base_q + AAw'(stride_q);
              state_q  <= StFetch;
            end else if (32'(f_q) != NUM_FILTERS - 1) begin
              f_q      <= f_q + FiltW'(1);
              w_base_q <= w_base_q + WAw'(KERNEL_SIZE);
              i_q      <= '0;
              a_base_q <= '0;
              state_q  <= StFetch;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          busy_q       <= 1'b0;
          load_ready_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.load_ovf   = load_ovf_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_filter = out_filter_q;
  assign bus.out_index  = out_index_q;

endmodule

// File: tb/tb_conv1d_pe.sv
// Scoreboard bench for conv1d_pe: directed loads/runs push expected results, a monitor pops them.
module tb_conv1d_pe;

  localparam int DW = 16;
  localparam int KS = 3;
  localparam int NF = 2;
  localparam int AD = 64;

  typedef struct {
    int f;
    int i;
    int d;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t exp_q[$];
  int   ld_buf[8];

  conv1d_pe_if #(.DATA_WIDTH(DW), .NUM_FILTERS(NF), .ACT_DEPTH(AD)) bus ();

  conv1d_pe #(
    .DATA_WIDTH  (DW),
    .ACC_WIDTH   (40),
    .FRAC_BITS   (0),
    .KERNEL_SIZE (KS),
    .NUM_FILTERS (NF),
    .ACT_DEPTH   (AD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input int f, input int i, input int d);
    exp_t e;
    e.f = f;
    e.i = i;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted result is compared against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got f=%0d i=%0d d=%0d, expected none",
                   bus.out_filter, bus.out_index, $signed(bus.out_data));
        end else begin
          e = exp_q.pop_front();
          if (int'(bus.out_filter) != e.f || int'(bus.out_index) != e.i ||
              int'($signed(bus.out_data)) != e.d) begin
            errors++;
            $display("FAIL out_result: got f=%0d i=%0d d=%0d, expected f=%0d i=%0d d=%0d",
                     bus.out_filter, bus.out_index, $signed(bus.out_data), e.f, e.i, e.d);
          end
        end
      end
    end
  end

  task automatic load_burst(input logic sel, input int n);
    for (int j = 0; j < n; j++) begin
      check("load_ready", int'(bus.load_ready), 1);
      bus.load_valid = 1'b1;
      bus.load_sel   = sel;
      bus.load_last  = (j == n - 1);
      bus.load_data  = DW'(ld_buf[j]);
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic run_conv(input int len, input int stride, input logic relu, input int exp_err);
    int first_v;
    int done_cyc;
    int n_done;
    first_v  = -1;
    done_cyc = -1;
    n_done   = 0;
    bus.cfg_act_len = 7'(len);
    bus.cfg_stride  = 4'(stride);
    bus.cfg_relu    = relu;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (bus.out_valid && first_v < 0) begin
        first_v = cyc;
        check("busy_during_run", int'(bus.busy), 1);
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
        check("busy_at_done", int'(bus.busy), 0);
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    check("done_pulses", n_done, 1);
    check("cfg_err", int'(bus.cfg_err), exp_err);
    if (exp_err != 0) begin
      check("err_done_edge", done_cyc, 1);
      check("err_no_output", first_v, -1);
    end else begin
      check("first_valid_edge", first_v, KS + 2);
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic push_basic();
    int f0[3];
    int f1[3];
    f0 = '{14, 20, 26};
    f1 = '{3, 4, 5};
    for (int i = 0; i < 3; i++) push(0, i, f0[i]);
    for (int i = 0; i < 3; i++) push(1, i, f1[i]);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_sel   = 1'b0;
    bus.load_last  = 1'b0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.cfg_act_len = '0;
    bus.cfg_stride  = '0;
    bus.cfg_relu    = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_load_ready", int'(bus.load_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_load_ovf", int'(bus.load_ovf), 0);
    check("rst_cfg_err", int'(bus.cfg_err), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_load_ready", int'(bus.load_ready), 1);

    // Basic convolution
    ld_buf = '{1, 2, 3, 0, 0, 1, 0, 0};
    load_burst(1'b0, 6);
    ld_buf = '{1, 2, 3, 4, 5, 0, 0, 0};
    load_burst(1'b1, 5);
    check("no_ovf", int'(bus.load_ovf), 0);
    push_basic();
    run_conv(5, 1, 1'b0, 0);

    // Stride 2
    push(0, 0, 14); push(0, 1, 26); push(1, 0, 3); push(1, 1, 5);
    run_conv(5, 2, 1'b0, 0);

    // Backpressure on the first result
    push_basic();
    bus.out_ready = 1'b0;
    fork
      run_conv(5, 1, 1'b0, 0);
      begin
        for (int c = 0; c < 50 && !bus.out_valid; c++) begin
          @(posedge clk); #1;
        end
        for (int c = 0; c < 10; c++) begin
          check("stall_valid", int'(bus.out_valid), 1);
          check("stall_data", int'($signed(bus.out_data)), 14);
          check("stall_filter", int'(bus.out_filter), 0);
          check("stall_index", int'(bus.out_index), 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join

    // Reset during the second output's accumulation
    push_basic();
    bus.cfg_act_len = 7'd5;
    bus.cfg_stride  = 4'd1;
    bus.cfg_relu    = 1'b0;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 50 && !bus.out_valid; c++) begin
      @(posedge clk); #1;
    end
    check("midrst_first_valid", int'(bus.out_valid), 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_out_data", int'(bus.out_data), 0);
    check("midrst_load_ready", int'(bus.load_ready), 0);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_idle_ready", int'(bus.load_ready), 1);
    check("midrst_no_done", int'(bus.done), 0);
    push_basic();
    run_conv(5, 1, 1'b0, 0);

    // Configuration errors
    run_conv(2, 1, 1'b0, 1);
    run_conv(5, 0, 1'b0, 1);
    run_conv(65, 1, 1'b0, 1);

    // Weight overflow keeps the first six words
    ld_buf = '{1, 2, 3, 0, 0, 1, 99, 0};
    load_burst(1'b0, 7);
    check("load_ovf", int'(bus.load_ovf), 1);
    push_basic();
    run_conv(5, 1, 1'b0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("ovf_cleared", int'(bus.load_ovf), 0);

    // Negative results with and without ReLU
    ld_buf = '{-1, -1, -1, 0, 0, 0, 0, 0};
    load_burst(1'b0, 6);
    push(0, 0, -6); push(0, 1, -9); push(0, 2, -12);
    push(1, 0, 0); push(1, 1, 0); push(1, 2, 0);
    run_conv(5, 1, 1'b0, 0);
    for (int f = 0; f < 2; f++) for (int i = 0; i < 3; i++) push(f, i, 0);
    run_conv(5, 1, 1'b1, 0);

    // Saturation at both rails
    ld_buf = '{32767, 32767, 0, -32768, -32768, 0, 0, 0};
    load_burst(1'b0, 6);
    ld_buf = '{2, 2, 2, 0, 0, 0, 0, 0};
    load_burst(1'b1, 3);
    push(0, 0, 32767);
    push(1, 0, -32768);
    run_conv(3, 1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
